// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, state
// encodings and the datapath mux/ALU select codes.
package mc_pkg;

  localparam int OP_ADDU  = 0;
  localparam int OP_SUBU  = 1;
  localparam int OP_ORI   = 2;
  localparam int OP_LW    = 3;
  localparam int OP_SW    = 4;
  localparam int OP_BEQ   = 5;
  localparam int OP_JAL   = 6;
  localparam int OP_BNE   = 7;
  localparam int OP_ADDIU = 8;
  localparam int OP_LUI   = 9;
  localparam int OP_JR    = 10;
  localparam int OP_SLT   = 11;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_DEC    = 4'd1,
    S_REXEC  = 4'd2,
    S_RFIN   = 4'd3,
    S_IEXEC  = 4'd4,
    S_IFIN   = 4'd5,
    S_MCALC  = 4'd6,
    S_MLOAD  = 4'd7,
    S_MLDFIN = 4'd8,
    S_MSTORE = 4'd9,
    S_BR     = 4'd10,
    S_JAL    = 4'd11,
    S_JR     = 4'd12,
    S_ERR    = 4'd13
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  localparam logic [1:0] ALU_B_FOUR   = 2'b00;
  localparam logic [1:0] ALU_B_RB     = 2'b01;
  localparam logic [1:0] ALU_B_BRANCH = 2'b10;
  localparam logic [1:0] ALU_B_EXT    = 2'b11;

  localparam logic [1:0] PC_TARGET = 2'b00;
  localparam logic [1:0] PC_ALU    = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RA     = 2'b11;

  localparam logic [1:0] RF_W_RT  = 2'b00;
  localparam logic [1:0] RF_W_RD  = 2'b01;
  localparam logic [1:0] RF_W_R31 = 2'b10;

  localparam logic [1:0] RF_DIN_DR  = 2'b00;
  localparam logic [1:0] RF_DIN_ALU = 2'b01;
  localparam logic [1:0] RF_DIN_PC  = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_IMEM    = 2'b01;
  localparam logic [1:0] ERR_DMEM    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

endpackage

// File: rtl/mc_watchdog.sv
// Bus wait watchdog: counts unacknowledged request cycles and flags the
// cycle in which the wait budget runs out. TIMEOUT = 0 disables it.
module mc_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_ack,
  output logic o_timeout
);

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] LAST = (TIMEOUT > 0) ? WC_W'(TIMEOUT - 1) : '0;

  logic [WC_W-1:0] r_wait_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_wait_cnt <= '0;
    else if (i_clr)          r_wait_cnt <= '0;
    else if (i_en && !i_ack) r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  // An ack in the last allowed cycle suppresses the timeout.
  assign o_timeout = (TIMEOUT != 0) && i_en && !i_ack && (r_wait_cnt == LAST);

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control FSM with req/ack memory handshake, bus watchdog,
// illegal-op trap and retired-instruction counter.
module mc_ctrl_hs
  import mc_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  i_op,
  input  logic             i_zf,
  input  logic             i_imem_ack,
  input  logic             i_dmem_ack,
  output logic             o_im_req,
  output logic             o_dm_rd_req,
  output logic             o_dm_wr_req,
  output logic             o_pc_wr,
  output logic             o_ir_wr,
  output logic             o_ab_wr,
  output logic             o_target_wr,
  output logic             o_alu_wr,
  output logic             o_dr_wr,
  output logic             o_rf_wr,
  output logic             o_ext_sz,
  output logic             o_alu_a_sel,
  output logic [1:0]       o_alu_b_sel,
  output logic [2:0]       o_alu_ctrl,
  output logic [1:0]       o_pc_sel,
  output logic [1:0]       o_rf_w_sel,
  output logic [1:0]       o_rf_din_sel,
  output logic [3:0]       o_state,
  output logic             o_retire,
  output logic [CNT_W-1:0] o_retired_cnt,
  output logic             o_err,
  output logic [1:0]       o_err_code
);

  state_t           r_state, w_next;
  logic             r_err;
  logic [1:0]       r_err_code, w_err_code;
  logic [CNT_W-1:0] r_retired_cnt;

  logic w_im_req, w_dm_rd_req, w_dm_wr_req;
  logic w_pc_wr, w_ir_wr, w_ab_wr, w_target_wr, w_alu_wr, w_dr_wr, w_rf_wr;
  logic w_retire, w_timeout, w_wd_en, w_wd_clr, w_wd_ack;

  assign w_wd_en  = (r_state == S_IF) || (r_state == S_MLOAD) || (r_state == S_MSTORE);
  assign w_wd_ack = (r_state == S_IF) ? i_imem_ack : i_dmem_ack;
  assign w_wd_clr = (w_next != r_state) &&
                    ((w_next == S_IF) || (w_next == S_MLOAD) || (w_next == S_MSTORE));

  mc_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_wd_clr),
    .i_en      (w_wd_en),
    .i_ack     (w_wd_ack),
    .o_timeout (w_timeout)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next       = r_state;
    w_err_code   = ERR_NONE;
    w_im_req     = 1'b0;
    w_dm_rd_req  = 1'b0;
    w_dm_wr_req  = 1'b0;
    w_pc_wr      = 1'b0;
    w_ir_wr      = 1'b0;
    w_ab_wr      = 1'b0;
    w_target_wr  = 1'b0;
    w_alu_wr     = 1'b0;
    w_dr_wr      = 1'b0;
    w_rf_wr      = 1'b0;
    w_retire     = 1'b0;
    o_ext_sz     = 1'b1;
    o_alu_a_sel  = 1'b0;
    o_alu_b_sel  = ALU_B_FOUR;
    o_alu_ctrl   = ALU_ADD;
    o_pc_sel     = PC_TARGET;
    o_rf_w_sel   = RF_W_RT;
    o_rf_din_sel = RF_DIN_DR;
    case (r_state)
      S_IF: begin
        w_im_req = 1'b1;
        o_pc_sel = PC_ALU;
        if (i_imem_ack) begin
          w_pc_wr = 1'b1;
          w_ir_wr = 1'b1;
          w_next  = S_DEC;
        end else if (w_timeout) begin
          w_next     = S_ERR;
          w_err_code = ERR_IMEM;
        end
      end
      S_DEC: begin
        w_ab_wr     = 1'b1;
        w_target_wr = 1'b1;
        o_alu_b_sel = ALU_B_BRANCH;
        case (i_op)
          OP_W'(OP_ADDU), OP_W'(OP_SUBU), OP_W'(OP_SLT): w_next = S_REXEC;
          OP_W'(OP_ORI), OP_W'(OP_ADDIU), OP_W'(OP_LUI): w_next = S_IEXEC;
          OP_W'(OP_LW), OP_W'(OP_SW):                    w_next = S_MCALC;
          OP_W'(OP_BEQ), OP_W'(OP_BNE):                  w_next = S_BR;
          OP_W'(OP_JAL):                                 w_next = S_JAL;
          OP_W'(OP_JR):                                  w_next = S_JR;
          default: begin
            w_next     = S_ERR;
            w_err_code = ERR_ILLEGAL;
          end
        endcase
      end
      S_REXEC: begin
        o_alu_a_sel = 1'b1;
        o_alu_b_sel = ALU_B_RB;
        w_alu_wr    = 1'b1;
        w_next      = S_RFIN;
        if (i_op == OP_W'(OP_SUBU))     o_alu_ctrl = ALU_SUB;
        else if (i_op == OP_W'(OP_SLT)) o_alu_ctrl = ALU_SLT;
      end
      S_RFIN: begin
        o_rf_w_sel   = RF_W_RD;
        o_rf_din_sel = RF_DIN_ALU;
        w_rf_wr      = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_IF;
      end
      S_IEXEC: begin
        o_alu_a_sel = 1'b1;
        o_alu_b_sel = ALU_B_EXT;
        w_alu_wr    = 1'b1;
        w_next      = S_IFIN;
        if (i_op == OP_W'(OP_ORI)) begin
          o_ext_sz   = 1'b0;
          o_alu_ctrl = ALU_OR;
        end else if (i_op == OP_W'(OP_LUI)) begin
          o_alu_ctrl = ALU_LUI;
        end
      end
      S_IFIN: begin
        o_rf_din_sel = RF_DIN_ALU;
        w_rf_wr      = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_IF;
      end
      S_MCALC: begin
        o_alu_a_sel = 1'b1;
        o_alu_b_sel = ALU_B_EXT;
        w_alu_wr    = 1'b1;
        w_next      = (i_op == OP_W'(OP_SW)) ? S_MSTORE : S_MLOAD;
      end
      S_MLOAD: begin
        w_dm_rd_req = 1'b1;
        if (i_dmem_ack) begin
          w_dr_wr = 1'b1;
          w_next  = S_MLDFIN;
        end else if (w_timeout) begin
          w_next     = S_ERR;
          w_err_code = ERR_DMEM;
        end
      end
      S_MLDFIN: begin
        o_rf_din_sel = RF_DIN_DR;
        w_rf_wr      = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_IF;
      end
      S_MSTORE: begin
        w_dm_wr_req = 1'b1;
        if (i_dmem_ack) begin
          w_retire = 1'b1;
          w_next   = S_IF;
        end else if (w_timeout) begin
          w_next     = S_ERR;
          w_err_code = ERR_DMEM;
        end
      end
      S_BR: begin
        o_alu_a_sel = 1'b1;
        o_alu_b_sel = ALU_B_RB;
        o_alu_ctrl  = ALU_SUB;
        o_pc_sel    = PC_TARGET;
        w_pc_wr     = (i_op == OP_W'(OP_BNE)) ? ~i_zf : i_zf;
        w_retire    = 1'b1;
        w_next      = S_IF;
      end
      S_JAL: begin
        o_pc_sel     = PC_JUMP;
        w_pc_wr      = 1'b1;
        o_rf_w_sel   = RF_W_R31;
        o_rf_din_sel = RF_DIN_PC;
        w_rf_wr      = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_IF;
      end
      S_JR: begin
        o_pc_sel = PC_RA;
        w_pc_wr  = 1'b1;
        w_retire = 1'b1;
        w_next   = S_IF;
      end
      S_ERR: w_next = S_ERR;
      default: w_next = S_IF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IF;
      r_err         <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_retired_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_ERR && r_state != S_ERR) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code;
      end
      if (w_retire) r_retired_cnt <= r_retired_cnt + 1'b1;
    end
  end

  // The state register already reads IF under reset; requests and enables
  // are masked so the datapath and memories see nothing until release.
  assign o_im_req      = w_im_req    & ~rst;
  assign o_dm_rd_req   = w_dm_rd_req & ~rst;
  assign o_dm_wr_req   = w_dm_wr_req & ~rst;
  assign o_pc_wr       = w_pc_wr     & ~rst;
  assign o_ir_wr       = w_ir_wr     & ~rst;
  assign o_ab_wr       = w_ab_wr     & ~rst;
  assign o_target_wr   = w_target_wr & ~rst;
  assign o_alu_wr      = w_alu_wr    & ~rst;
  assign o_dr_wr       = w_dr_wr     & ~rst;
  assign o_rf_wr       = w_rf_wr     & ~rst;
  assign o_retire      = w_retire    & ~rst;
  assign o_state       = r_state;
  assign o_retired_cnt = r_retired_cnt;
  assign o_err         = r_err;
  assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Scoreboard bench for mc_ctrl_hs: an instruction-level model queues the
// expected per-cycle control word, a monitor compares on each falling edge.
module tb_mc_ctrl_hs;
  import mc_pkg::*;

  localparam int OP_W    = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [OP_W-1:0] op = '0;
  logic zf = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;

  logic im_req, dm_rd_req, dm_wr_req, pc_wr, ir_wr, ab_wr, target_wr;
  logic alu_wr, dr_wr, rf_wr, ext_sz, alu_a_sel, retire, err;
  logic [1:0] alu_b_sel, pc_sel, rf_w_sel, rf_din_sel, err_code;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic [CNT_W-1:0] retired_cnt;

  always #5 clk = ~clk;

  mc_ctrl_hs #(.OP_W(OP_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_op(op), .i_zf(zf),
    .i_imem_ack(imem_ack), .i_dmem_ack(dmem_ack),
    .o_im_req(im_req), .o_dm_rd_req(dm_rd_req), .o_dm_wr_req(dm_wr_req),
    .o_pc_wr(pc_wr), .o_ir_wr(ir_wr), .o_ab_wr(ab_wr), .o_target_wr(target_wr),
    .o_alu_wr(alu_wr), .o_dr_wr(dr_wr), .o_rf_wr(rf_wr), .o_ext_sz(ext_sz),
    .o_alu_a_sel(alu_a_sel), .o_alu_b_sel(alu_b_sel), .o_alu_ctrl(alu_ctrl),
    .o_pc_sel(pc_sel), .o_rf_w_sel(rf_w_sel), .o_rf_din_sel(rf_din_sel),
    .o_state(state), .o_retire(retire), .o_retired_cnt(retired_cnt),
    .o_err(err), .o_err_code(err_code)
  );

  typedef struct packed {
    logic [3:0]       state;
    logic             im_req, dm_rd_req, dm_wr_req;
    logic             pc_wr, ir_wr, ab_wr, target_wr, alu_wr, dr_wr, rf_wr;
    logic             ext_sz, alu_a_sel;
    logic [1:0]       alu_b_sel;
    logic [2:0]       alu_ctrl;
    logic [1:0]       pc_sel, rf_w_sel, rf_din_sel;
    logic             retire, err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] retired_cnt;
  } obs_t;

  obs_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int dc_mode  = 0;  // don't-care ack value: 0 low, 1 high, 2 random

  logic [CNT_W-1:0] m_cnt  = '0;
  logic             m_err  = 1'b0;
  logic [1:0]       m_code = 2'b00;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t s;
    s.state = state;  s.im_req = im_req;  s.dm_rd_req = dm_rd_req;
    s.dm_wr_req = dm_wr_req;  s.pc_wr = pc_wr;  s.ir_wr = ir_wr;
    s.ab_wr = ab_wr;  s.target_wr = target_wr;  s.alu_wr = alu_wr;
    s.dr_wr = dr_wr;  s.rf_wr = rf_wr;  s.ext_sz = ext_sz;
    s.alu_a_sel = alu_a_sel;  s.alu_b_sel = alu_b_sel;  s.alu_ctrl = alu_ctrl;
    s.pc_sel = pc_sel;  s.rf_w_sel = rf_w_sel;  s.rf_din_sel = rf_din_sel;
    s.retire = retire;  s.err = err;  s.err_code = err_code;
    s.retired_cnt = retired_cnt;
    return s;
  endfunction

  // Everything the spec leaves unlisted is 0, except ext_sz which rests at 1.
  function automatic obs_t blank(input state_t st);
    obs_t b = '0;
    b.state = st;
    b.ext_sz = 1'b1;
    b.err = m_err;
    b.err_code = m_code;
    b.retired_cnt = m_cnt;
    return b;
  endfunction

  function automatic logic ack_val(input int v);
    if (v != 2) return v[0];
    if (dc_mode == 2) return 1'($urandom_range(0, 1));
    return dc_mode[0];
  endfunction

  // One clock cycle: drive inputs, queue the expected control word.
  task automatic push(input obs_t e, input int ia, input int da);
    imem_ack = ack_val(ia);
    dmem_ack = ack_val(da);
    exp_q.push_back(e);
    if (e.retire) m_cnt = m_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("ctrl_word t=%0t st=%0d", $time, e.state), 64'(sample()), 64'(e));
      end
    end
  end

  // Delays of TIMEOUT or more mean the memory never answers.
  task automatic run_instr(input int opn, input logic zf_v, input int id, input int dd,
                           output bit trapped);
    obs_t e;
    bit is_lw;
    op = OP_W'(opn);
    zf = zf_v;
    trapped = 1'b0;
    for (int k = 0; k < TIMEOUT; k++) begin
      e = blank(S_IF);
      e.im_req = 1'b1;
      e.pc_sel = 2'b01;
      if (k == id) begin
        e.pc_wr = 1'b1;
        e.ir_wr = 1'b1;
        push(e, 1, 2);
        break;
      end
      push(e, 0, 2);
    end
    if (id >= TIMEOUT) begin
      m_err = 1'b1; m_code = 2'b01; trapped = 1'b1;
      return;
    end
    e = blank(S_DEC);
    e.ab_wr = 1'b1; e.target_wr = 1'b1; e.alu_b_sel = 2'b10;
    push(e, 2, 2);
    case (opn)
      0, 1, 11: begin
        e = blank(S_REXEC);
        e.alu_a_sel = 1'b1; e.alu_b_sel = 2'b01; e.alu_wr = 1'b1;
        e.alu_ctrl = (opn == 1) ? 3'b001 : (opn == 11) ? 3'b011 : 3'b000;
        push(e, 2, 2);
        e = blank(S_RFIN);
        e.rf_w_sel = 2'b01; e.rf_din_sel = 2'b01; e.rf_wr = 1'b1; e.retire = 1'b1;
        push(e, 2, 2);
      end
      2, 8, 9: begin
        e = blank(S_IEXEC);
        e.alu_a_sel = 1'b1; e.alu_b_sel = 2'b11; e.alu_wr = 1'b1;
        e.ext_sz = (opn != 2);
        e.alu_ctrl = (opn == 2) ? 3'b010 : (opn == 9) ? 3'b100 : 3'b000;
        push(e, 2, 2);
        e = blank(S_IFIN);
        e.rf_din_sel = 2'b01; e.rf_wr = 1'b1; e.retire = 1'b1;
        push(e, 2, 2);
      end
      3, 4: begin
        is_lw = (opn == 3);
        e = blank(S_MCALC);
        e.alu_a_sel = 1'b1; e.alu_b_sel = 2'b11; e.alu_wr = 1'b1;
        push(e, 2, 2);
        for (int k = 0; k < TIMEOUT; k++) begin
          e = blank(is_lw ? S_MLOAD : S_MSTORE);
          e.dm_rd_req = is_lw;
          e.dm_wr_req = !is_lw;
          if (k == dd) begin
            e.dr_wr = is_lw;
            e.retire = !is_lw;
            push(e, 2, 1);
            break;
          end
          push(e, 2, 0);
        end
        if (dd >= TIMEOUT) begin
          m_err = 1'b1; m_code = 2'b10; trapped = 1'b1;
          return;
        end
        if (is_lw) begin
          e = blank(S_MLDFIN);
          e.rf_wr = 1'b1; e.retire = 1'b1;
          push(e, 2, 2);
        end
      end
      5, 7: begin
        e = blank(S_BR);
        e.alu_a_sel = 1'b1; e.alu_b_sel = 2'b01; e.alu_ctrl = 3'b001;
        e.pc_wr = (opn == 5) ? zf_v : !zf_v;
        e.retire = 1'b1;
        push(e, 2, 2);
      end
      6: begin
        e = blank(S_JAL);
        e.pc_sel = 2'b10; e.pc_wr = 1'b1; e.rf_w_sel = 2'b10;
        e.rf_din_sel = 2'b10; e.rf_wr = 1'b1; e.retire = 1'b1;
        push(e, 2, 2);
      end
      10: begin
        e = blank(S_JR);
        e.pc_sel = 2'b11; e.pc_wr = 1'b1; e.retire = 1'b1;
        push(e, 2, 2);
      end
      default: begin
        m_err = 1'b1; m_code = 2'b11; trapped = 1'b1;
      end
    endcase
  endtask

  task automatic err_idle(input int n);
    int saved = dc_mode;
    dc_mode = 2;
    for (int i = 0; i < n; i++) push(blank(S_ERR), 2, 2);
    dc_mode = saved;
  endtask

  // Acks are held high during reset to prove the enables stay masked.
  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    op = OP_W'($urandom_range(0, 15));
    @(negedge clk);
    check("rst_state", 64'(state), 64'(S_IF));
    check("rst_req_en", 64'({im_req, dm_rd_req, dm_wr_req, pc_wr, ir_wr, ab_wr,
                             target_wr, alu_wr, dr_wr, rf_wr}), 64'd0);
    check("rst_err", 64'({err, err_code}), 64'd0);
    check("rst_cnt", 64'(retired_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cnt = '0; m_err = 1'b0; m_code = 2'b00;
  endtask

  task automatic random_burst(input int n, input bit allow_illegal);
    bit t;
    int opn;
    for (int i = 0; i < n; i++) begin
      opn = allow_illegal && ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 15))
                                                         : int'($urandom_range(0, 11));
      run_instr(opn, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3)), t);
      if (t) begin
        err_idle(3);
        do_reset();
      end
    end
  endtask

  initial begin : stimulus
    bit t;
    do_reset();

    dc_mode = 1;
    run_instr(OP_ADDU, 1'b0, 0, 0, t);
    check("cnt_after_addu", 64'(retired_cnt), 64'(m_cnt));
    dc_mode = 0;

    run_instr(OP_LW, 1'b0, 0, 3, t);
    run_instr(OP_BEQ, 1'b0, 0, 0, t);
    run_instr(OP_BNE, 1'b0, 0, 0, t);
    run_instr(OP_JAL, 1'b0, 0, 0, t);
    run_instr(OP_JR, 1'b0, 0, 0, t);
    check("cnt_after_jal_jr", 64'(retired_cnt), 64'(m_cnt));

    run_instr(OP_ADDU, 1'b0, TIMEOUT - 1, 0, t);
    run_instr(OP_SW, 1'b0, 0, TIMEOUT - 1, t);
    run_instr(OP_LW, 1'b1, 2, TIMEOUT - 1, t);

    dc_mode = 2;
    random_burst(50, 1'b0);

    run_instr(OP_ORI, 1'b0, TIMEOUT, 0, t);
    err_idle(4);
    check("imem_timeout_err", 64'({err, err_code}), 64'(3'b101));
    do_reset();

    run_instr(OP_SUBU, 1'b0, 0, 0, t);
    run_instr(15, 1'b0, 0, 0, t);
    err_idle(3);
    do_reset();

    run_instr(OP_SW, 1'b0, 1, TIMEOUT, t);
    err_idle(3);
    do_reset();

    run_instr(OP_LW, 1'b0, 0, TIMEOUT, t);
    err_idle(2);
    do_reset();

    random_burst(30, 1'b1);

    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("final_cnt", 64'(retired_cnt), 64'(m_cnt));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : time_guard
    #500000;
    $display("FAIL time_guard got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
